// File: rtl/core_lsu.sv
// Load/store unit: one memory command at a time, with a shared-stack guard.
// A guard violation dumps the core registers to the stack and raises an exception.
module core_lsu #(
  parameter int WIDTH       = 32,
  parameter int REGS_CODING = 3,
  parameter int NUM_REGS    = 8,
  parameter int STACK_CHECK = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_wren,
  input  logic [WIDTH-1:0]       cmd_addr,
  input  logic [WIDTH-1:0]       cmd_wdata,
  input  logic [REGS_CODING-1:0] cmd_reg,
  input  logic [WIDTH-1:0]       stack_begin,
  input  logic [WIDTH-1:0]       my_stack_begin,
  input  logic [WIDTH-1:0]       my_stack_end,
  input  logic [WIDTH-1:0]       sp_in,
  input  logic [WIDTH-1:0]       exc_addr,
  output logic [REGS_CODING-1:0] dump_sel,
  input  logic [WIDTH-1:0]       dump_data,
  output logic                   request,
  output logic                   wren,
  output logic [WIDTH-1:0]       address,
  output logic [WIDTH-1:0]       writedata,
  input  logic                   response,
  input  logic [WIDTH-1:0]       readdata,
  output logic                   rd_valid,
  output logic [REGS_CODING-1:0] rd_reg,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   sp_we,
  output logic [WIDTH-1:0]       sp_out,
  output logic                   exc_valid,
  output logic [WIDTH-1:0]       exc_ip,
  output logic                   busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ACCESS, S_DUMP_LOAD, S_DUMP_WRITE, S_EXC
  } state_t;

  localparam logic [REGS_CODING-1:0] CNT_INIT = REGS_CODING'(NUM_REGS - 1);

  state_t                 state_q, state_d;
  logic                   request_q, request_d;
  logic                   wren_q, wren_d;
  logic [WIDTH-1:0]       address_q, address_d;
  logic [WIDTH-1:0]       writedata_q, writedata_d;
  logic                   rd_valid_q, rd_valid_d;
  logic [REGS_CODING-1:0] rd_reg_q, rd_reg_d;
  logic [WIDTH-1:0]       rd_data_q, rd_data_d;
  logic                   sp_we_q, sp_we_d;
  logic [WIDTH-1:0]       sp_out_q, sp_out_d;
  logic                   exc_valid_q, exc_valid_d;
  logic [WIDTH-1:0]       exc_ip_q, exc_ip_d;
  logic [WIDTH-1:0]       sp_cur_q, sp_cur_d;
  logic [REGS_CODING-1:0] cnt_q, cnt_d;
  logic                   in_window;
  logic                   violation;

  assign in_window = (cmd_addr >= my_stack_begin) && (cmd_addr < my_stack_end);
  assign violation = (STACK_CHECK != 0) && (cmd_addr >= stack_begin) && !in_window;

  always_comb begin
    state_d     = state_q;
    request_d   = request_q;
    wren_d      = wren_q;
    address_d   = address_q;
    writedata_d = writedata_q;
    rd_valid_d  = 1'b0;
    rd_reg_d    = rd_reg_q;
    rd_data_d   = rd_data_q;
    sp_we_d     = 1'b0;
    sp_out_d    = sp_out_q;
    exc_valid_d = 1'b0;
    exc_ip_d    = exc_ip_q;
    sp_cur_d    = sp_cur_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (violation) begin
            sp_cur_d = sp_in;
            cnt_d    = CNT_INIT;
            state_d  = S_DUMP_LOAD;
          end else begin
            address_d   = cmd_addr;
            writedata_d = cmd_wdata;
            wren_d      = cmd_wren;
            rd_reg_d    = cmd_reg;
            request_d   = 1'b1;
            state_d     = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (response) begin
          request_d = 1'b0;
          wren_d    = 1'b0;
          state_d   = S_IDLE;
          if (!wren_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = readdata;
          end
        end
      end
      S_DUMP_LOAD: begin
        writedata_d = dump_data;
        address_d   = sp_cur_q;
        wren_d      = 1'b1;
        request_d   = 1'b1;
        sp_cur_d    = sp_cur_q + WIDTH'(1);
        state_d     = S_DUMP_WRITE;
      end
      S_DUMP_WRITE: begin
        if (response) begin
          request_d = 1'b0;
          wren_d    = 1'b0;
          if (cnt_q == '0) begin
            // Pulses are registered so they line up with the EXC state.
            exc_valid_d = 1'b1;
            exc_ip_d    = exc_addr;
            sp_we_d     = 1'b1;
            sp_out_d    = sp_in + WIDTH'(NUM_REGS);
            state_d     = S_EXC;
          end else begin
            cnt_d   = cnt_q - REGS_CODING'(1);
            state_d = S_DUMP_LOAD;
          end
        end
      end
      S_EXC: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      request_q   <= 1'b0;
      wren_q      <= 1'b0;
      address_q   <= '0;
      writedata_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_reg_q    <= '0;
      rd_data_q   <= '0;
      sp_we_q     <= 1'b0;
      sp_out_q    <= '0;
      exc_valid_q <= 1'b0;
      exc_ip_q    <= '0;
      sp_cur_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      request_q   <= request_d;
      wren_q      <= wren_d;
      address_q   <= address_d;
      writedata_q <= writedata_d;
      rd_valid_q  <= rd_valid_d;
      rd_reg_q    <= rd_reg_d;
      rd_data_q   <= rd_data_d;
      sp_we_q     <= sp_we_d;
      sp_out_q    <= sp_out_d;
      exc_valid_q <= exc_valid_d;
      exc_ip_q    <= exc_ip_d;
      sp_cur_q    <= sp_cur_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign dump_sel  = cnt_q;
  assign request   = request_q;
  assign wren      = wren_q;
  assign address   = address_q;
  assign writedata = writedata_q;
  assign rd_valid  = rd_valid_q;
  assign rd_reg    = rd_reg_q;
  assign rd_data   = rd_data_q;
  assign sp_we     = sp_we_q;
  assign sp_out    = sp_out_q;
  assign exc_valid = exc_valid_q;
  assign exc_ip    = exc_ip_q;

endmodule

// File: tb/tb_core_lsu.sv
// Scoreboard bench for core_lsu: directed commands, queued expectations,
// monitors compare every memory handshake, load result and exception.
module tb_core_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_valid0;
  logic        cmd_wren;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [2:0]  cmd_reg;
  logic [31:0] stack_begin, my_stack_begin, my_stack_end, sp_in, exc_addr;
  logic        response, resp_m, spur, response0;
  logic [31:0] readdata, dump_data, dump_data0;

  logic        cmd_ready, request, wren, rd_valid, sp_we, exc_valid, busy;
  logic [31:0] address, writedata, rd_data, sp_out, exc_ip;
  logic [2:0]  dump_sel, rd_reg;

  logic        cmd_ready0, request0, wren0, rd_valid0, sp_we0, exc_valid0, busy0;
  logic [31:0] address0, writedata0, rd_data0, sp_out0, exc_ip0;
  logic [2:0]  dump_sel0, rd_reg0;

  int checks = 0;
  int errors = 0;
  int mem_lat = 0;
  bit mem_en = 1'b1;
  int mem_seen = 0;
  int rcnt = 0;

  logic [64:0] exp_mem[$];
  logic [34:0] exp_rd[$];
  logic [63:0] exp_exc[$];

  always #5 clk = ~clk;

  assign dump_data  = 32'hA0 + {29'd0, dump_sel};
  assign dump_data0 = 32'hA0 + {29'd0, dump_sel0};
  assign response   = resp_m | spur;
  assign readdata   = (address == 32'h20) ? 32'hDEADBEEF : (address ^ 32'h5A5A0000);

  core_lsu dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wren(cmd_wren),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_reg(cmd_reg),
    .stack_begin(stack_begin), .my_stack_begin(my_stack_begin),
    .my_stack_end(my_stack_end), .sp_in(sp_in), .exc_addr(exc_addr),
    .dump_sel(dump_sel), .dump_data(dump_data),
    .request(request), .wren(wren), .address(address), .writedata(writedata),
    .response(response), .readdata(readdata),
    .rd_valid(rd_valid), .rd_reg(rd_reg), .rd_data(rd_data),
    .sp_we(sp_we), .sp_out(sp_out), .exc_valid(exc_valid), .exc_ip(exc_ip),
    .busy(busy)
  );

  core_lsu #(.STACK_CHECK(0)) dut0 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_wren(cmd_wren),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_reg(cmd_reg),
    .stack_begin(stack_begin), .my_stack_begin(my_stack_begin),
    .my_stack_end(my_stack_end), .sp_in(sp_in), .exc_addr(exc_addr),
    .dump_sel(dump_sel0), .dump_data(dump_data0),
    .request(request0), .wren(wren0), .address(address0), .writedata(writedata0),
    .response(response0), .readdata(32'h0),
    .rd_valid(rd_valid0), .rd_reg(rd_reg0), .rd_data(rd_data0),
    .sp_we(sp_we0), .sp_out(sp_out0), .exc_valid(exc_valid0), .exc_ip(exc_ip0),
    .busy(busy0)
  );

  task automatic cmp(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory model: answers each request after mem_lat waiting cycles.
  always begin
    @(posedge clk);
    #1;
    if (!mem_en) begin
      resp_m = 1'b0;
    end else if (resp_m) begin
      resp_m = 1'b0;
      rcnt = 0;
    end else if (request) begin
      if (rcnt >= mem_lat) resp_m = 1'b1;
      else rcnt++;
    end else begin
      rcnt = 0;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (request && response) begin
        mem_seen++;
        if (exp_mem.size() == 0)
          cmp("mem_unexpected", {31'd0, wren, address, writedata}, 96'd0);
        else
          cmp("mem_access", {31'd0, wren, address, writedata}, {31'd0, exp_mem.pop_front()});
      end
      if (rd_valid) begin
        if (exp_rd.size() == 0)
          cmp("rd_unexpected", {61'd0, rd_reg, rd_data}, 96'd0);
        else
          cmp("rd_result", {61'd0, rd_reg, rd_data}, {61'd0, exp_rd.pop_front()});
      end
      if (exc_valid || sp_we) begin
        if (exp_exc.size() == 0)
          cmp("exc_unexpected", {30'd0, exc_valid, sp_we, exc_ip, sp_out}, 96'd0);
        else
          cmp("exc_pulse", {30'd0, exc_valid, sp_we, exc_ip, sp_out},
              {30'd0, 2'b11, exp_exc.pop_front()});
      end
    end
  end

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] r, input bit keep);
    int n = 0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_wren = w;
    cmd_addr = a;
    cmd_wdata = d;
    cmd_reg = r;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) cmp("issue_timeout", 96'd0, 96'd1);
    @(posedge clk);
    #1;
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    @(negedge clk);
    while ((busy || exp_mem.size() != 0 || exp_rd.size() != 0 || exp_exc.size() != 0)
           && n < 300) begin
      @(negedge clk);
      n++;
    end
    cmp(nm, {64'd0, 16'(exp_mem.size()), 8'(exp_rd.size()), 7'(exp_exc.size()), busy},
        96'd0);
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_valid0 = 1'b0;
    cmd_wren = 1'b0;
    cmd_addr = '0;
    cmd_wdata = '0;
    cmd_reg = '0;
    stack_begin = 32'h1000;
    my_stack_begin = 32'h1100;
    my_stack_end = 32'h1200;
    sp_in = 32'h1150;
    exc_addr = 32'h400;
    resp_m = 1'b0;
    spur = 1'b0;
    response0 = 1'b0;
    #12;
    cmp("reset_ctrl", {89'd0, cmd_ready, busy, request, wren, rd_valid, sp_we, exc_valid},
        {89'd0, 7'b1000000});
    cmp("reset_data", {address, writedata, rd_data}, 96'd0);
    cmp("reset_misc", {29'd0, dump_sel, sp_out, exc_ip}, 96'd0);
    @(negedge clk);
    reset = 1'b0;

    // Load below the shared stack, two wait cycles
    mem_lat = 2;
    exp_mem.push_back({1'b0, 32'h20, 32'h0});
    exp_rd.push_back({3'd3, 32'hDEADBEEF});
    issue(1'b0, 32'h20, 32'h0, 3'd3, 1'b0);
    wait_idle("load_done");

    // Store at window begin, held three cycles
    mem_lat = 3;
    exp_mem.push_back({1'b1, 32'h1100, 32'h55});
    issue(1'b1, 32'h1100, 32'h55, 3'd0, 1'b0);
    @(negedge clk);
    cmp("store_held", {63'd0, request, wren, address}, {63'd0, 2'b11, 32'h1100});
    wait_idle("store_done");

    // Edges of the guard window that stay legal
    mem_lat = 0;
    exp_mem.push_back({1'b0, 32'h0FFF, 32'h0});
    exp_rd.push_back({3'd2, 32'h0FFF ^ 32'h5A5A0000});
    issue(1'b0, 32'h0FFF, 32'h0, 3'd2, 1'b0);
    exp_mem.push_back({1'b0, 32'h11FF, 32'h0});
    exp_rd.push_back({3'd4, 32'h11FF ^ 32'h5A5A0000});
    issue(1'b0, 32'h11FF, 32'h0, 3'd4, 1'b0);
    wait_idle("legal_edges");

    // Violation at my_stack_end: eight dump words, then exception
    for (int i = 0; i < 8; i++)
      exp_mem.push_back({1'b1, 32'h1150 + i, 32'hA7 - i});
    exp_exc.push_back({32'h400, 32'h1158});
    issue(1'b1, 32'h1200, 32'h99, 3'd0, 1'b0);
    wait_idle("viol_dump");

    // Violating load just below the window, sp wraps during dump
    sp_in = 32'hFFFFFFFE;
    exc_addr = 32'h800;
    for (int i = 0; i < 8; i++)
      exp_mem.push_back({1'b1, 32'hFFFFFFFE + i, 32'hA7 - i});
    exp_exc.push_back({32'h800, 32'h6});
    issue(1'b0, 32'h10FF, 32'h0, 3'd1, 1'b0);
    wait_idle("viol_wrap");
    sp_in = 32'h1150;
    exc_addr = 32'h400;

    // Empty window: any address in the shared stack violates
    my_stack_begin = 32'h1300;
    my_stack_end = 32'h1300;
    for (int i = 0; i < 8; i++)
      exp_mem.push_back({1'b1, 32'h1150 + i, 32'hA7 - i});
    exp_exc.push_back({32'h400, 32'h1158});
    issue(1'b0, 32'h1300, 32'h0, 3'd1, 1'b0);
    wait_idle("viol_empty_win");
    my_stack_begin = 32'h1100;
    my_stack_end = 32'h1200;

    // Guard disabled: same violating store is a plain access
    @(posedge clk);
    #1;
    cmd_wren = 1'b1;
    cmd_addr = 32'h1200;
    cmd_wdata = 32'h77;
    cmd_reg = 3'd6;
    cmd_valid0 = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid0 = 1'b0;
    @(negedge clk);
    cmp("nochk_req", {29'd0, busy0, request0, wren0, address0, writedata0},
        {29'd0, 3'b111, 32'h1200, 32'h77});
    @(posedge clk);
    #1;
    response0 = 1'b1;
    @(posedge clk);
    #1;
    response0 = 1'b0;
    repeat (3) @(negedge clk);
    cmp("nochk_done", {29'd0, rd_reg0, rd_data0, sp_out0},
        {29'd0, 3'd6, 32'd0, 32'd0});
    cmp("nochk_flags", {87'd0, cmd_ready0, busy0, request0, wren0, rd_valid0, sp_we0,
        exc_valid0, exc_ip0 == 32'd0, 1'b0}, {87'd0, 9'b100000010});

    // Back-pressure: second command held while the first is in flight
    mem_lat = 3;
    exp_mem.push_back({1'b0, 32'h30, 32'h0});
    exp_rd.push_back({3'd1, 32'h30 ^ 32'h5A5A0000});
    exp_mem.push_back({1'b0, 32'h34, 32'h0});
    exp_rd.push_back({3'd5, 32'h34 ^ 32'h5A5A0000});
    issue(1'b0, 32'h30, 32'h0, 3'd1, 1'b1);
    @(negedge clk);
    cmp("bp_not_ready", {93'd0, cmd_valid, cmd_ready, busy}, {93'd0, 3'b101});
    issue(1'b0, 32'h34, 32'h0, 3'd5, 1'b0);
    wait_idle("bp_done");

    // Stray responses in IDLE are ignored
    mem_en = 1'b0;
    @(posedge clk);
    #1;
    spur = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    spur = 1'b0;
    mem_en = 1'b1;
    @(negedge clk);
    cmp("spurious_resp", {93'd0, rd_valid, request, busy}, 96'd0);

    // Reset while the fourth dump word is stalled
    mem_lat = 0;
    mem_seen = 0;
    for (int i = 0; i < 3; i++)
      exp_mem.push_back({1'b1, 32'h1150 + i, 32'hA7 - i});
    issue(1'b1, 32'h2000, 32'h0, 3'd0, 1'b0);
    begin
      int n = 0;
      while (mem_seen < 3 && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    mem_lat = 100;
    cmp("rst_three_words", 96'(mem_seen), 96'd3);
    repeat (3) @(negedge clk);
    cmp("rst_stalled", {93'd0, request, wren, busy}, {93'd0, 3'b111});
    #2;
    reset = 1'b1;
    #1;
    cmp("rst_abort", {92'd0, request, busy, exc_valid, sp_we}, 96'd0);
    @(negedge clk);
    reset = 1'b0;
    mem_lat = 0;
    repeat (2) @(negedge clk);
    cmp("rst_quiet", {94'd0, exc_valid, sp_we}, 96'd0);
    exp_mem.push_back({1'b0, 32'h40, 32'h0});
    exp_rd.push_back({3'd5, 32'h40 ^ 32'h5A5A0000});
    issue(1'b0, 32'h40, 32'h0, 3'd5, 1'b0);
    wait_idle("post_reset_load");

    repeat (5) @(negedge clk);
    cmp("queues_empty", {64'd0, 16'(exp_mem.size()), 8'(exp_rd.size()), 8'(exp_exc.size())},
        96'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
